// File: rtl/uart_core.sv
// uart_core: full-duplex UART, 16x RX oversampling with 3-sample majority vote, RX word valid one clock after the stop sample.
// TX accepts only when idle; RX holds its word until i_rx_ready and drops newer words (o_rx_overrun). Option: UART_CORE_BREAK_DETECT_EN adds o_rx_break.
module uart_core #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     i_baud_div,
  input  logic [1:0]           i_parity_mode,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_busy,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_overrun,
`ifdef UART_CORE_BREAK_DETECT_EN
  output logic                 o_rx_break,
`endif
  output logic [2:0]           o_rx_state,
  output logic [2:0]           o_tx_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  state_t               tx_state, tx_next;
  logic [DIV_W-1:0]     tx_div, tx_cnt;
  logic [3:0]           tx_tick_cnt, tx_bit_idx;
  logic                 tx_stop_idx, tx_par_en, tx_par_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_accept, tx_tick, tx_bit_end;

  assign tx_accept  = i_tx_valid && (tx_state == S_IDLE);
  assign tx_tick    = (tx_cnt == tx_div);
  assign tx_bit_end = tx_tick && (tx_tick_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_accept) tx_next = S_START;
      S_START:  if (tx_bit_end) tx_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_bit_idx == 4'(DATA_BITS-1)) tx_next = tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_next = S_STOP;
      S_STOP:   if (tx_bit_end && tx_stop_idx == 1'(STOP_BITS-1)) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      S_START:  o_tx_serial = 1'b0;
      S_DATA:   o_tx_serial = tx_shreg[0];
      S_PARITY: o_tx_serial = tx_par_bit;
      default:  o_tx_serial = 1'b1;
    endcase
    o_tx_ready = (tx_state == S_IDLE);
    o_tx_busy  = (tx_state != S_IDLE);
    o_tx_state = tx_state;
  end

  // Divisor and parity mode are frozen per frame at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_div      <= '0;
      tx_cnt      <= '0;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_shreg    <= '0;
    end else if (tx_accept) begin
      tx_div      <= i_baud_div;
      tx_cnt      <= '0;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_par_en   <= i_parity_mode[0] ^ i_parity_mode[1];
      tx_par_bit  <= (^i_tx_data) ^ (i_parity_mode == 2'b10);
      tx_shreg    <= i_tx_data;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_cnt      <= '0;
        tx_tick_cnt <= tx_tick_cnt + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + DIV_W'(1);
      end
      if (tx_bit_end && tx_state == S_DATA) begin
        tx_shreg   <= tx_shreg >> 1;
        tx_bit_idx <= tx_bit_idx + 4'd1;
      end
      if (tx_bit_end && tx_state == S_STOP) tx_stop_idx <= ~tx_stop_idx;
    end
  end

  state_t               rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [DIV_W-1:0]     rx_div, rx_cnt;
  logic [3:0]           rx_tick_cnt, rx_bit_idx;
  logic                 rx_par_en, rx_par_odd, rx_par_bit;
  logic [1:0]           rx_smp;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_fall, rx_start, rx_tick, rx_mid, rx_bit_end, rx_maj, rx_done, rx_perr;

  assign rx_fall    = rx_s3 & ~rx_s2;
  assign rx_tick    = (rx_cnt == rx_div);
  assign rx_mid     = rx_tick && (rx_tick_cnt == 4'd9);
  assign rx_bit_end = rx_tick && (rx_tick_cnt == 4'd15);
  assign rx_maj     = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s2) | (rx_smp[1] & rx_s2);
  assign rx_perr    = rx_par_en & (rx_par_bit ^ (^rx_shreg) ^ rx_par_odd);

`ifdef UART_CORE_BREAK_DETECT_EN
  logic rx_break_hold, rx_is_break;
  assign rx_is_break = (rx_shreg == '0) && !rx_maj && !(rx_par_en && rx_par_bit);
  assign rx_start    = (rx_state == S_IDLE) && rx_fall && !rx_break_hold;
  assign o_rx_break  = rx_break_hold;
`else
  assign rx_start    = (rx_state == S_IDLE) && rx_fall;
`endif

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  // STOP exits at the stop-bit mid-point so a following start edge is not missed.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_start) rx_next = S_START;
      S_START:  if (rx_mid && rx_maj) rx_next = S_IDLE;
                else if (rx_bit_end) rx_next = S_DATA;
      S_DATA:   if (rx_bit_end && rx_bit_idx == 4'(DATA_BITS-1)) rx_next = rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_bit_end) rx_next = S_STOP;
      S_STOP:   if (rx_mid) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done    = (rx_state == S_STOP) && rx_mid;
    o_rx_state = rx_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
      rx_div      <= '0;
      rx_cnt      <= '0;
      rx_tick_cnt <= '0;
      rx_bit_idx  <= '0;
      rx_par_en   <= 1'b0;
      rx_par_odd  <= 1'b0;
      rx_par_bit  <= 1'b0;
      rx_smp      <= '0;
      rx_shreg    <= '0;
    end else begin
      rx_s1 <= i_rx_serial;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_start) begin
        rx_div      <= i_baud_div;
        rx_cnt      <= '0;
        rx_tick_cnt <= '0;
        rx_bit_idx  <= '0;
        rx_par_en   <= i_parity_mode[0] ^ i_parity_mode[1];
        rx_par_odd  <= (i_parity_mode == 2'b10);
      end else if (rx_state != S_IDLE) begin
        if (rx_tick) begin
          rx_cnt      <= '0;
          rx_tick_cnt <= rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == 4'd7) rx_smp[0] <= rx_s2;
          if (rx_tick_cnt == 4'd8) rx_smp[1] <= rx_s2;
        end else begin
          rx_cnt <= rx_cnt + DIV_W'(1);
        end
        if (rx_mid && rx_state == S_DATA)   rx_shreg   <= {rx_maj, rx_shreg[DATA_BITS-1:1]};
        if (rx_mid && rx_state == S_PARITY) rx_par_bit <= rx_maj;
        if (rx_bit_end && rx_state == S_DATA) rx_bit_idx <= rx_bit_idx + 4'd1;
      end
    end
  end

  // A same-cycle consumer handshake frees the slot, so the new word replaces the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_valid      <= 1'b0;
      o_rx_data       <= '0;
      o_rx_frame_err  <= 1'b0;
      o_rx_parity_err <= 1'b0;
      o_rx_overrun    <= 1'b0;
`ifdef UART_CORE_BREAK_DETECT_EN
      rx_break_hold   <= 1'b0;
`endif
    end else begin
      o_rx_overrun <= 1'b0;
`ifdef UART_CORE_BREAK_DETECT_EN
      if (rx_break_hold && rx_s2) rx_break_hold <= 1'b0;
`endif
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
      if (rx_done) begin
`ifdef UART_CORE_BREAK_DETECT_EN
        if (rx_is_break) rx_break_hold <= 1'b1;
        else
`endif
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_valid      <= 1'b1;
          o_rx_data       <= rx_shreg;
          o_rx_frame_err  <= ~rx_maj;
          o_rx_parity_err <= rx_perr;
        end else begin
          o_rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform, loopback, injected RX frames, overrun and reset cases.
module tb_uart_core;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [15:0] baud_div;
  logic [1:0] parity_mode;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_serial, tx_busy;
  logic       rx_line, rx_drv, rx_loop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_ferr, rx_perr, rx_ovr;
  logic [2:0] rx_state, tx_state;
`ifdef UART_CORE_BREAK_DETECT_EN
  logic       rx_break;
`endif

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  rx_exp_t exp_q[$];

  always #5 clk = ~clk;
  assign rx_line = rx_loop ? tx_serial : rx_drv;

  uart_core dut (
    .clk(clk), .rst(rst), .i_baud_div(baud_div), .i_parity_mode(parity_mode),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_tx_serial(tx_serial), .o_tx_busy(tx_busy), .i_rx_serial(rx_line),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_rx_frame_err(rx_ferr), .o_rx_parity_err(rx_perr), .o_rx_overrun(rx_ovr),
`ifdef UART_CORE_BREAK_DETECT_EN
    .o_rx_break(rx_break),
`endif
    .o_rx_state(rx_state), .o_tx_state(tx_state)
  );

  // Scoreboard consumer: every delivered RX word is compared to the head of exp_q.
  task automatic rx_monitor();
    rx_exp_t got, e;
    forever begin
      @(negedge clk);
      if (rx_ovr) ovr_cnt++;
      if (!rst && rx_valid && rx_ready) begin
        got = {rx_data, rx_ferr, rx_perr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got data=%h ferr=%b perr=%b, no word expected", rx_data, rx_ferr, rx_perr);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rx_word: got data=%h ferr=%b perr=%b, want data=%h ferr=%b perr=%b",
                     got.data, got.ferr, got.perr, e.data, e.ferr, e.perr);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic rx_bit(input logic v, input int div);
    rx_drv = v;
    repeat (16*(div+1)) @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [7:0] d, input logic par_en, input logic par_v,
                        input logic stop_v, input logic rdy_at_stop);
    rx_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) rx_bit(d[i], 1);
    if (par_en) rx_bit(par_v, 1);
    if (rdy_at_stop) rx_ready = 1'b1;
    rx_bit(stop_v, 1);
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
      errors++; $display("FAIL reset_tx: got serial/ready/busy=%b want 110", {tx_serial, tx_ready, tx_busy});
    end
    checks++;
    if ({rx_valid, rx_ferr, rx_perr, rx_ovr} !== 4'b0000) begin
      errors++; $display("FAIL reset_rx_flags: got %b want 0000", {rx_valid, rx_ferr, rx_perr, rx_ovr});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    checks++;
    if ({tx_state, rx_state} !== 6'd0) begin
      errors++; $display("FAIL reset_states: got tx=%0d rx=%0d want 0 0", tx_state, rx_state);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_tx_wave();
    logic [319:0] cap, exp;
    logic [9:0]   frm;
    logic         busy0, rdy_before, rdy_after;
    frm = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 320; k++) exp[k] = frm[k/32];
    send(8'hA5);
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      cap[k] = tx_serial;
      if (k == 0)   busy0 = tx_busy;
      if (k == 319) rdy_before = tx_ready;
    end
    @(negedge clk);
    rdy_after = tx_ready;
    checks++;
    if (cap !== exp) begin
      errors++; $display("FAIL tx_wave: got %h want %h", cap, exp);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++; $display("FAIL tx_busy_start: got %b want 1", busy0);
    end
    checks++;
    if (rdy_before !== 1'b0) begin
      errors++; $display("FAIL tx_ready_319: got %b want 0", rdy_before);
    end
    checks++;
    if (rdy_after !== 1'b1) begin
      errors++; $display("FAIL tx_ready_320: got %b want 1", rdy_after);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loopback_even();
    logic par_line;
    rx_loop = 1'b1;
    parity_mode = 2'b01;
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send(8'h3C);
    repeat (9*32+16+1) @(negedge clk);
    par_line = tx_serial;
    checks++;
    if (par_line !== 1'b0) begin
      errors++; $display("FAIL loop_parity_bit: got %b want 0", par_line);
    end
    wait_drain(1000);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL loop_drain: %0d words outstanding, want 0", exp_q.size());
    end
    repeat (60) @(posedge clk); #1;
    rx_loop = 1'b0;
  endtask

  task automatic test_parity_err();
    parity_mode = 2'b10;
    exp_q.push_back({8'h55, 1'b0, 1'b1});
    inject(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL parity_err_drain: %0d words outstanding, want 0", exp_q.size());
    end
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_frame_err();
    parity_mode = 2'b00;
    exp_q.push_back({8'h5A, 1'b1, 1'b0});
    inject(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL frame_err_drain: %0d words outstanding, want 0", exp_q.size());
    end
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_break();
    parity_mode = 2'b00;
`ifndef UART_CORE_BREAK_DETECT_EN
    exp_q.push_back({8'h00, 1'b1, 1'b0});
`endif
    rx_drv = 1'b0;
    repeat (10*32) @(posedge clk); #1;
`ifdef UART_CORE_BREAK_DETECT_EN
    checks++;
    if ({rx_break, rx_valid} !== 2'b10) begin
      errors++; $display("FAIL break_set: got break/valid=%b want 10", {rx_break, rx_valid});
    end
    rx_drv = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (rx_break !== 1'b0) begin
      errors++; $display("FAIL break_clear: got %b want 0", rx_break);
    end
`else
    rx_drv = 1'b1;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL break_word_drain: %0d words outstanding, want 0", exp_q.size());
    end
`endif
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    int start;
    rx_ready = 1'b0;
    start = ovr_cnt;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    inject(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    inject(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL overrun_hold: got valid=%b data=%h want 1 11", rx_valid, rx_data);
    end
    checks++;
    if (ovr_cnt - start !== 1) begin
      errors++; $display("FAIL overrun_pulse: got %0d cycles high want 1", ovr_cnt - start);
    end
    rx_ready = 1'b1;
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL overrun_drain: %0d words outstanding, want 0", exp_q.size());
    end
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int start;
    rx_ready = 1'b0;
    start = ovr_cnt;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    exp_q.push_back({8'h22, 1'b0, 1'b0});
    inject(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    inject(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: %0d words outstanding, want 0", exp_q.size());
    end
    checks++;
    if (ovr_cnt - start !== 0) begin
      errors++; $display("FAIL b2b_no_overrun: got %0d cycles high want 0", ovr_cnt - start);
    end
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_tx();
    parity_mode = 2'b00;
    send(8'h00);
    repeat (3*32+10) @(negedge clk);
    checks++;
    if ({tx_serial, tx_state} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL rst_mid_before: got serial=%b state=%0d want 0 2", tx_serial, tx_state);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_serial, tx_ready, tx_state} !== {1'b1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL rst_mid_after: got serial=%b ready=%b state=%0d want 1 1 0", tx_serial, tx_ready, tx_state);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx_loop = 1'b1;
    parity_mode = 2'b01;
    exp_q.push_back({8'h0F, 1'b0, 1'b0});
    send(8'h0F);
    wait_drain(1000);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rst_new_frame_drain: %0d words outstanding, want 0", exp_q.size());
    end
    repeat (60) @(posedge clk); #1;
    rx_loop = 1'b0;
    parity_mode = 2'b00;
  endtask

  task automatic test_glitch();
    logic saw_start, saw_valid;
    saw_start = 1'b0;
    saw_valid = 1'b0;
    baud_div = 16'd3;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx_drv = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rx_state == 3'd1) saw_start = 1'b1;
      if (rx_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_start !== 1'b1) begin
      errors++; $display("FAIL glitch_start_seen: got %b want 1", saw_start);
    end
    checks++;
    if ({saw_valid, rx_state} !== 4'b0000) begin
      errors++; $display("FAIL glitch_false_start: got valid_seen=%b state=%0d want 0 0", saw_valid, rx_state);
    end
    @(posedge clk); #1;
    baud_div = 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    baud_div = 16'd1;
    parity_mode = 2'b00;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_drv = 1'b1;
    rx_loop = 1'b0;
    rx_ready = 1'b1;
    fork
      rx_monitor();
    join_none
    test_reset();
    test_tx_wave();
    test_loopback_even();
    test_parity_err();
    test_frame_err();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid_tx();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised successor to the fixed 8N1 transceiver. Full-duplex UART engine with a compile-time frame format (data bits, stop bits) and a run-time baud divisor and parity mode.
- RX path uses 16x oversampling with 3-sample majority voting, and reports framing, parity and overrun errors.
- Sits between the pins and the system FIFOs. Both the TX and RX system sides use valid/ready handshakes.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9; LSB sent first.
- STOP_BITS, 1, TX stop bits; legal values 1 or 2; RX checks only the first stop bit.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_baud_div  in  DIV_W  oversample tick period minus 1. One tick every (i_baud_div+1) clocks; one bit = 16 ticks.
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- i_tx_data  in  DATA_BITS  word to transmit.
- i_tx_valid  in  1  TX word offered.
- o_tx_ready  out  1  TX engine idle; word accepted when i_tx_valid && o_tx_ready.
- o_tx_serial  out  1  serial line out; idle high.
- o_tx_busy  out  1  frame in progress.
- i_rx_serial  in  1  asynchronous serial line in.
- o_rx_data  out  DATA_BITS  received word.
- o_rx_valid  out  1  o_rx_data and the error flags are valid.
- i_rx_ready  in  1  consumer accepts the RX word.
- o_rx_frame_err  out  1  stop bit sampled 0; qualified by o_rx_valid.
- o_rx_parity_err  out  1  parity mismatch; qualified by o_rx_valid.
- o_rx_overrun  out  1  one-cycle pulse: a completed word was dropped.
- o_rx_state  out  3  RX FSM state, for test.
- o_tx_state  out  3  TX FSM state, for test.

Behaviour:
- Reset values:
  - o_tx_serial=1, o_tx_ready=1, o_tx_busy=0.
  - o_rx_valid=0, all error flags 0, o_rx_data=0.
  - Both FSMs in IDLE, tick counters cleared.
  - The RX synchroniser flops reset to 1.
- Reset asserted mid-frame aborts both engines immediately. o_tx_serial returns to 1 on the next clock.
- i_baud_div and i_parity_mode are sampled at frame start (TX accept or RX start detect) and held for that frame.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - On accept, the TX tick divider restarts and START begins the next cycle. o_tx_serial goes low and o_tx_ready goes low in that same cycle.
  - Each bit lasts exactly 16*(div+1) clocks.
  - DATA sends DATA_BITS bits, LSB first. PARITY is skipped when the mode is none.
  - STOP drives 1 for STOP_BITS bit periods, then the FSM returns to IDLE and o_tx_ready rises.
  - Total frame = (1+DATA_BITS+P+STOP_BITS) bit periods, where P=1 if parity is enabled, else 0.
  - Even parity: parity bit = XOR of the data. Odd parity: its inverse.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - 2-flop synchroniser, then falling-edge detect. An edge in IDLE enters START and restarts the RX tick divider.
  - Each bit is sampled at oversample ticks 7, 8 and 9 and resolved by majority vote.
  - Start-bit majority =1 is a false start: return to IDLE, no flags, no output.
  - The FSM leaves STOP at the first stop-bit mid-point (after the tick-9 sample), so back-to-back frames are caught.
- RX output:
  - One cycle after the stop sample: o_rx_valid=1, o_rx_data loaded, and both error flags loaded.
  - These outputs are held until the cycle where o_rx_valid && i_rx_ready, then o_rx_valid clears.
  - A word is delivered even with an error.
- Overrun: a new word completes while o_rx_valid=1 and i_rx_ready=0.
  - The new word is discarded and the held word is kept.
  - o_rx_overrun pulses high for 1 cycle.
  - If i_rx_ready=1 in that same cycle, there is no overrun: the new word replaces the old one.
- The divisor value 0 is legal and gives one tick per clock (bit = 16 clocks).

Optional Feature:
- Macro: UART_CORE_BREAK_DETECT_EN.
- Defined: adds output o_rx_break (1 bit), reset 0.
  - Set when the RX line holds 0 for a full frame including the stop bit (data all 0 and framing error).
  - The break word is not delivered: no o_rx_valid.
  - o_rx_break stays high until the line returns to 1; the RX FSM waits in IDLE until a rising edge is seen.
- Undefined: no o_rx_break port. A break is reported as a normal word 0 with o_rx_frame_err=1.

Test Plan:
- i_baud_div=1, parity none, send 0xA5 → o_tx_serial low for 32 clocks, then 1,0,1,0,0,1,0,1 at 32 clocks each, then high for 32. o_tx_ready returns high 320 clocks after accept.
- Loop o_tx_serial into i_rx_serial, send 0x3C with even parity → o_rx_valid with o_rx_data=0x3C, parity bit 0 on the line, frame_err=0, parity_err=0.
- Inject a serial frame of 0x55 with the parity bit inverted, odd mode → o_rx_data=0x55, o_rx_parity_err=1.
- Stop bit forced 0 → o_rx_frame_err=1. With the macro on and the line low for a whole frame → o_rx_break=1 and no o_rx_valid.
- Two back-to-back RX frames 0x11 then 0x22 with i_rx_ready=0 → o_rx_data stays 0x11 and o_rx_overrun pulses for exactly 1 cycle. Repeat with i_rx_ready=1 at completion → 0x22 delivered, no pulse.
- Assert rst mid-DATA on TX, deassert, then send 0x0F → line is high after reset and the new frame is correct. A 3-clock low glitch with i_baud_div=3 → false start, no o_rx_valid.
